// File: rtl/mmio_unit_pkg.sv
// Shared constants and types for the p18240 memory-mapped I/O unit.
// Address defaults and the debouncer state encoding live here.
package mmio_unit_pkg;

  localparam logic [15:0] MMIO_SW_ADDR   = 16'h2000;
  localparam logic [15:0] MMIO_CYC_ADDR  = 16'h2002;
  localparam logic [15:0] MMIO_STAT_ADDR = 16'h2004;

  typedef enum logic {DB_STABLE, DB_COUNT} dbState_t;

endpackage

// File: rtl/mmio_unit_sw_debouncer.sv
// Two-flop switch synchroniser followed by a debouncer that only accepts a new
// value after it has held for DEBOUNCE_CYCLES consecutive cycles.
module sw_debouncer
  import mmio_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] SW,
  output logic [15:0] swDeb,
  output logic        changed
);

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [15:0] sync1_q, sync2_q;
  logic [15:0] sw_deb_q, sw_deb_d;
  logic [15:0] sw_cand_q, sw_cand_d;
  logic [7:0]  db_cnt_q, db_cnt_d;
  dbState_t    state_q, state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_deb_q  <= '0;
      sw_cand_q <= '0;
      db_cnt_q  <= '0;
      state_q   <= DB_STABLE;
    end else begin
      sync1_q   <= SW;
      sync2_q   <= sync1_q;
      sw_deb_q  <= sw_deb_d;
      sw_cand_q <= sw_cand_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    db_cnt_d  = db_cnt_q;
    sw_deb_d  = sw_deb_q;
    sw_cand_d = sw_cand_q;
    changed   = 1'b0;
    case (state_q)
      DB_STABLE: begin
        if (sync2_q != sw_deb_q) begin
          state_d   = DB_COUNT;
          db_cnt_d  = 8'd1;
          sw_cand_d = sync2_q;
        end
      end
      DB_COUNT: begin
        if (sync2_q == sw_deb_q) begin
          state_d  = DB_STABLE;
          db_cnt_d = 8'd0;
        end else if (sync2_q != sw_cand_q) begin
          // A third value appeared mid-count: start over on the new candidate.
          db_cnt_d  = 8'd1;
          sw_cand_d = sync2_q;
        end else if (db_cnt_q == DB_LIMIT) begin
          sw_deb_d = sync2_q;
          changed  = 1'b1;
          state_d  = DB_STABLE;
          db_cnt_d = 8'd0;
        end else begin
          db_cnt_d = db_cnt_q + 8'd1;
        end
      end
    endcase
  end

  assign swDeb = sw_deb_q;

endmodule

// File: rtl/mmio_unit.sv
// Memory-mapped I/O unit: LED register, debounced switches, cycle counter and
// sticky status. The cycle counter is built only when MMIO_CYCLE_COUNTER_EN is defined.
module mmio_unit
  import mmio_unit_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [15:0] SW_ADDR         = MMIO_SW_ADDR,
  parameter logic [15:0] CYC_ADDR        = MMIO_CYC_ADDR,
  parameter logic [15:0] STAT_ADDR       = MMIO_STAT_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] memAddr,
  input  logic        re_L,
  input  logic        we_L,
  inout  wire  [15:0] dataBus,
  input  logic [15:0] SW,
  output logic [15:0] LEDR,
  output logic        hit
);

  logic        sel_sw, sel_cyc, sel_stat;
  logic        wr_en, rd_en;
  logic [15:0] sw_deb;
  logic        sw_changed;
  logic [15:0] led_q, led_d;
  logic [1:0]  status_q, status_d;
  logic [1:0]  status_clr;
  logic [15:0] cyc_rd;
  logic        wrap_set;
  logic [15:0] rd_data;

  assign sel_sw   = (memAddr == SW_ADDR);
  assign sel_cyc  = (memAddr == CYC_ADDR);
  assign sel_stat = (memAddr == STAT_ADDR);
  assign hit      = sel_sw | sel_cyc | sel_stat;
  // A simultaneous read+write strobe is treated as a write; the bus stays released.
  assign wr_en    = ~we_L & hit;
  assign rd_en    = ~re_L & we_L & hit;

  sw_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debouncer (
    .clock  (clock),
    .reset  (reset),
    .SW     (SW),
    .swDeb  (sw_deb),
    .changed(sw_changed)
  );

`ifdef MMIO_CYCLE_COUNTER_EN
  logic [15:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + 16'd1;
    wrap_set  = (cyc_cnt_q == 16'hFFFF);
    if (wr_en && sel_cyc) begin
      cyc_cnt_d = dataBus;
      wrap_set  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cyc_cnt_q <= '0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign cyc_rd = cyc_cnt_q;
`else
  assign cyc_rd   = 16'h0000;
  assign wrap_set = 1'b0;
`endif

  always_comb begin
    led_d      = led_q;
    status_clr = 2'b00;
    if (wr_en && sel_sw)   led_d      = dataBus;
    if (wr_en && sel_stat) status_clr = dataBus[1:0];
    // Hardware set events win over a same-cycle write-1-to-clear.
    status_d = (status_q & ~status_clr) | {wrap_set, sw_changed};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      status_q <= '0;
    end else begin
      led_q    <= led_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    rd_data = 16'h0000;
    if (sel_sw)        rd_data = sw_deb;
    else if (sel_cyc)  rd_data = cyc_rd;
    else if (sel_stat) rd_data = {14'b0, status_q};
  end

  assign dataBus = rd_en ? rd_data : 16'hzzzz;
  assign LEDR    = led_q;

endmodule

// File: tb/tb_mmio_unit.sv
// Self-checking bench for mmio_unit: decode table, directed corner sequences,
// then randomized traffic checked against a run-length behavioural model.
module tb_mmio_unit;

  localparam int          N     = 4;
  localparam logic [15:0] A_SW  = 16'h2000;
  localparam logic [15:0] A_CYC = 16'h2002;
  localparam logic [15:0] A_ST  = 16'h2004;
  localparam logic [15:0] A_MISS = 16'h3000;
`ifdef MMIO_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [15:0] mem_addr, tb_data, sw, ledr;
  logic        re_l, we_l, hit;
  wire  [15:0] data_bus;

  assign data_bus = we_l ? 16'hzzzz : tb_data;

  mmio_unit #(.DEBOUNCE_CYCLES(N)) dut (
    .clock  (clk),
    .reset  (rst),
    .memAddr(mem_addr),
    .re_L   (re_l),
    .we_L   (we_l),
    .dataBus(data_bus),
    .SW     (sw),
    .LEDR   (ledr),
    .hit    (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  logic [15:0] m_s1, m_s2, m_deb, m_run_val, m_led, m_cyc;
  int          m_run, m_run_n;
  logic [1:0]  m_stat, m_clr;
  logic        m_load, m_wr, m_wrap;

  function automatic logic model_hit(input logic [15:0] a);
    return (a == A_SW) || (a == A_CYC) || (a == A_ST);
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a == A_SW)  return m_deb;
    if (a == A_CYC) return CYC_EN ? m_cyc : 16'h0000;
    if (a == A_ST)  return {14'b0, m_stat};
    return 16'h0000;
  endfunction

  // New switch value is accepted once the synchronised input has shown it for N+1 samples in a row.
  always_comb begin
    m_run_n = (m_s2 == m_run_val) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_load  = (m_s2 != m_deb) && (m_run_n >= N + 1);
    m_wr    = !we_l && model_hit(mem_addr);
    m_clr   = (m_wr && mem_addr == A_ST) ? tb_data[1:0] : 2'b00;
    m_wrap  = CYC_EN && !(m_wr && mem_addr == A_CYC) && (m_cyc == 16'hFFFF);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= 0; m_s2 <= 0; m_deb <= 0; m_run_val <= 0; m_run <= 0;
      m_led <= 0; m_cyc <= 0; m_stat <= 0;
    end else begin
      m_s1      <= sw;
      m_s2      <= m_s1;
      m_run     <= m_run_n;
      m_run_val <= m_s2;
      if (m_load) m_deb <= m_s2;
      if (m_wr && mem_addr == A_SW) m_led <= tb_data;
      if (m_wr && mem_addr == A_CYC) m_cyc <= tb_data;
      else                           m_cyc <= m_cyc + 16'd1;
      m_stat <= (m_stat & ~m_clr) | {m_wrap, m_load};
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else $display("ok   %s: %h", nm, act);
  endtask

  // Released bus: 4-state sims see Z, 2-state sims resolve it to 0.
  task automatic chk_z(input string nm);
    checks++;
    if (data_bus !== 16'hzzzz && data_bus !== 16'h0000) begin
      errors++;
      $display("FAIL %s: bus driven with %h expected released", nm, data_bus);
    end else $display("ok   %s: released", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string nm);
    mem_addr = a; re_l = 1'b0; we_l = 1'b1;
    #1;
    chk(nm, data_bus, exp);
    re_l = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_addr = a; tb_data = d; we_l = 1'b0; re_l = 1'b1;
    step();
    we_l = 1'b1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        re;
    logic        exp_hit;
    logic        exp_z;
    logic [15:0] exp_bus;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Decode/read table, valid once switches settle at A5A5 with status = 01.
    tbl[0] = '{A_SW,   1'b0, 1'b1, 1'b0, 16'hA5A5};
    tbl[1] = '{A_ST,   1'b0, 1'b1, 1'b0, 16'h0001};
    tbl[2] = '{A_SW,   1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[3] = '{A_MISS, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[4] = '{16'h2001, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[5] = '{16'h2006, 1'b0, 1'b0, 1'b1, 16'h0000};
    tbl[6] = '{A_ST,   1'b1, 1'b1, 1'b1, 16'h0000};
    tbl[7] = '{16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};

    rst = 1'b1; mem_addr = 16'h0000; re_l = 1'b1; we_l = 1'b1; tb_data = 0; sw = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ledr", ledr, 16'h0000);
    rd(A_SW, 16'h0000, "reset_sw_read");
    rst = 1'b0;
    rd(A_ST, 16'h0000, "reset_status");
    rd(A_CYC, 16'h0000, "reset_cyc");
    step();

    // Two-cycle glitch must be rejected.
    sw = 16'h0001;
    step(); step();
    sw = 16'h0000;
    repeat (10) step();
    rd(A_SW, 16'h0000, "glitch_swdeb");
    rd(A_ST, 16'h0000, "glitch_status");

    // Clean step: accepted after 2 + N + 1 edges.
    sw = 16'hA5A5;
    repeat (2 + N) step();
    rd(A_SW, 16'h0000, "sw_before_settle");
    step();
    rd(A_SW, 16'hA5A5, "sw_settled");
    rd(A_ST, 16'h0001, "status_after_settle");
    repeat (3) step();

    for (int i = 0; i < 8; i++) begin
      mem_addr = tbl[i].addr; re_l = tbl[i].re; we_l = 1'b1;
      #1;
      chk($sformatf("tbl%0d_hit", i), {15'b0, hit}, {15'b0, tbl[i].exp_hit});
      if (tbl[i].exp_z) chk_z($sformatf("tbl%0d_bus", i));
      else              chk($sformatf("tbl%0d_bus", i), data_bus, tbl[i].exp_bus);
      re_l = 1'b1;
    end
    step();

    wr(A_ST, 16'h0001);
    rd(A_ST, 16'h0000, "w1c_status0");

    wr(A_SW, 16'h00FF);
    chk("led_write", ledr, 16'h00FF);
    mem_addr = A_MISS; re_l = 1'b0;
    #1;
    chk("miss_hit", {15'b0, hit}, 16'h0000);
    chk_z("miss_bus");
    re_l = 1'b1;

    // Simultaneous strobes behave as a write.
    mem_addr = A_SW; tb_data = 16'h00AA; re_l = 1'b0; we_l = 1'b0;
    step();
    re_l = 1'b1; we_l = 1'b1;
    chk("illegal_strobe_write", ledr, 16'h00AA);

    // Debounce completion coincides with a write-1-to-clear of status[0].
    sw = 16'h5A5A;
    repeat (2 + N) step();
    wr(A_ST, 16'h0001);
    rd(A_ST, 16'h0001, "set_beats_clear");
    rd(A_SW, 16'h5A5A, "sw_5a5a");
    wr(A_ST, 16'h0001);

`ifdef MMIO_CYCLE_COUNTER_EN
    wr(A_CYC, 16'hFFFE);
    rd(A_CYC, 16'hFFFE, "cyc_written");
    step();
    rd(A_CYC, 16'hFFFF, "cyc_ffff");
    rd(A_ST, 16'h0000, "no_wrap_yet");
    step();
    rd(A_CYC, 16'h0000, "cyc_wrapped");
    rd(A_ST, 16'h0002, "wrap_status");
    wr(A_ST, 16'h0002);
    rd(A_ST, 16'h0000, "wrap_cleared");
    wr(A_CYC, 16'hFFFF);
    rd(A_ST, 16'h0000, "write_ffff_no_wrap");
    step();
    rd(A_ST, 16'h0002, "wrap_after_ffff");
    wr(A_ST, 16'h0002);
`else
    wr(A_CYC, 16'h1234);
    rd(A_CYC, 16'h0000, "cyc_absent_read");
    rd(A_ST, 16'h0000, "cyc_absent_status");
`endif

    // Asynchronous reset in the middle of a debounce count.
    wr(A_SW, 16'h1234);
    chk("led_1234", ledr, 16'h1234);
    sw = 16'h0F0F;
    repeat (4) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_led", ledr, 16'h0000);
    rd(A_SW, 16'h0000, "async_rst_swdeb");
    rd(A_CYC, 16'h0000, "async_rst_cyc");
    rd(A_ST, 16'h0000, "async_rst_status");
    step();
    rst = 1'b0;
    repeat (2 + N) step();
    rd(A_SW, 16'h0000, "post_rst_no_early_load");
    step();
    rd(A_SW, 16'h0F0F, "post_rst_settle");

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      int op, ap;
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: sw = 16'h0000;
          1: sw = 16'hFFFF;
          2: sw = 16'h1234;
          default: sw = 16'($urandom);
        endcase
      end
      ap = $urandom_range(0, 3);
      a  = (ap == 0) ? A_SW : (ap == 1) ? A_CYC : (ap == 2) ? A_ST : A_MISS;
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        mem_addr = a; re_l = 1'b0; we_l = 1'b1;
        #1;
        chk($sformatf("rnd%0d_hit", i), {15'b0, hit}, {15'b0, model_hit(a)});
        if (model_hit(a)) chk($sformatf("rnd%0d_rd", i), data_bus, model_read(a));
        else              chk_z($sformatf("rnd%0d_rd", i));
        re_l = 1'b1;
        step();
      end else if (op == 3) begin
        logic [15:0] d;
        case ($urandom_range(0, 3))
          0: d = 16'hFFFE;
          1: d = 16'hFFFD;
          default: d = 16'($urandom);
        endcase
        wr(a, d);
      end else begin
        step();
      end
      chk($sformatf("rnd%0d_led", i), ledr, m_led);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_unit.md
# mmio_unit

Memory-mapped I/O unit on the p18240 data bus, directly downstream of the datapath. It consumes `memAddr`, `re_L`, `we_L` and `dataBus`, and decodes three word addresses. On reads it drives `dataBus`; on writes it captures `dataBus`. It owns the LED output register, a synchronised and debounced switch input, a free-running cycle counter and a sticky status register.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a new synchronised switch value must hold before it is accepted. Legal range 1..255.
- `SW_ADDR`, default 16'h2000: switch data (read) / LED data (write).
- `CYC_ADDR`, default 16'h2002: cycle counter.
- `STAT_ADDR`, default 16'h2004: status register.

Ports:
- `clock` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high. Reset is asynchronous and active-high; `clock` is the only clock.
- `memAddr` input 16: registered MAR from the datapath.
- `re_L` input 1: active-low read strobe.
- `we_L` input 1: active-low write strobe.
- `dataBus` inout 16: shared bus. Driven only as defined below; Z otherwise.
- `SW` input 16: raw, asynchronous board switches.
- `LEDR` output 16: LED register.
- `hit` output 1: combinational. High when `memAddr` equals one of the three addresses; external memory must suppress its own drive when `hit` is 1.

## Operation
- Switch path:
  - `SW` passes through a 2-flop synchroniser to give `swSync`.
  - A debouncer FSM has two states, `DB_STABLE` and `DB_COUNT`, with an 8-bit counter `dbCnt` and a 16-bit `swDeb` register.
  - In `DB_STABLE`: if `swSync != swDeb`, go to `DB_COUNT` with `dbCnt = 1`.
  - In `DB_COUNT`: if `swSync == swDeb`, return to `DB_STABLE` (glitch rejected).
  - In `DB_COUNT`, otherwise: if `dbCnt == DEBOUNCE_CYCLES`, load `swDeb <= swSync`, set `status[0]` and go to `DB_STABLE`. Else increment `dbCnt`.
  - If `swSync` changes to a third value while in `DB_COUNT`, restart with `dbCnt = 1`. This requires tracking the candidate value `swCand`.
- Reads: `dataBus` is driven when `re_L == 0 && we_L == 1 && hit`.
  - `SW_ADDR` returns `swDeb`.
  - `CYC_ADDR` returns `cycCnt`.
  - `STAT_ADDR` returns `{14'b0, status[1:0]}`.
- Writes: take effect on the rising edge when `we_L == 0 && hit`.
  - `SW_ADDR`: `LEDR <= dataBus`.
  - `CYC_ADDR`: `cycCnt <= dataBus`.
  - `STAT_ADDR`: write-1-to-clear on `status[1:0]` using `dataBus[1:0]`.
- Cycle counter: `cycCnt` increments by 1 every cycle, modulo 2^16. On the wrap from 16'hFFFF to 16'h0000 it sets `status[1]`.
- Illegal `re_L == 0 && we_L == 0`: the write is performed and `dataBus` is not driven.

## Timing
- Reset values:
  - `LEDR`: 0.
  - `swDeb`, `swCand`, both synchroniser flops: 0.
  - `cycCnt`: 0.
  - `status`: 0.
  - FSM: `DB_STABLE`, with `dbCnt = 0`.
  - `dataBus`: Z.
- Reset asserted mid-debounce or mid-access aborts everything to the reset values immediately, with no clock required.
- Read latency: zero. Data is a combinational function of registered state, valid within the cycle `re_L` is low, and the datapath samples it into the MDR at the same edge.
- Write latency: `LEDR` and the target registers show the new value one edge after the strobe.
- Switch latency: a clean step on `SW` appears in `swDeb` after 2 (sync) + `DEBOUNCE_CYCLES` + 1 edges.
- Precedence within one cycle:
  - Hardware set beats write-1-to-clear on the same `status` bit.
  - A write to `CYC_ADDR` beats the increment; the next cycle increments the written value.
  - A write of 16'hFFFF to `CYC_ADDR` does not set `status[1]`; only the increment wrap does.

## Configuration
- `MMIO_CYCLE_COUNTER_EN` defined: cycle counter and `status[1]` are present, as described above.
- Undefined:
  - No counter flops are built.
  - `CYC_ADDR` still decodes (`hit = 1`) and reads 16'h0000.
  - Writes to `CYC_ADDR` are ignored.
  - `status[1]` is constant 0.

## Structure
- Shared package constants:
  - Address constants `MMIO_SW_ADDR`, `MMIO_CYC_ADDR`, `MMIO_STAT_ADDR`, used as parameter defaults.
  - `typedef enum logic {DB_STABLE, DB_COUNT} dbState_t`.
- Sub-module `sw_debouncer` contains the synchroniser and FSM. It has parameter `DEBOUNCE_CYCLES`, inputs `clock`, `reset`, `SW`, and outputs `swDeb` and a one-cycle `changed` pulse.
- Top-level `mmio_unit` holds decode, `LEDR`, `cycCnt`, `status` and the tri-state driver.

## Test plan
- Reset, then read `SW_ADDR` with `SW = 16'hA5A5` held 10 cycles → `dataBus = 16'hA5A5`, `status = 2'b01`. Before switch settle, `dataBus = 0`.
- `SW` pulses to 16'h0001 for 2 cycles with `DEBOUNCE_CYCLES = 4` → `swDeb` stays 0, `status[0]` stays 0.
- Write 16'h00FF to `SW_ADDR` → `LEDR = 16'h00FF` next edge. A read with `memAddr = 16'h3000` → `hit = 0`, `dataBus` Z.
- Write 16'hFFFE to `CYC_ADDR` → reads 16'hFFFF one cycle later and then 0. `status[1] = 1`; write 16'h0002 to `STAT_ADDR` → `status[1] = 0`.
- Debounce completion on the same edge as a write of 16'h0001 to `STAT_ADDR` → `status[0]` remains 1.
- Assert `reset` asynchronously mid-`DB_COUNT` with `LEDR = 16'h1234` → `LEDR = 0`, FSM `DB_STABLE`, `cycCnt = 0` before the next clock edge. Without `MMIO_CYCLE_COUNTER_EN`, a `CYC_ADDR` read returns 0.
